// File: rtl/neo_pkg.sv
// Shared definitions for the NEO energy writer and the spike reader.
// Keeps the sample width tied to the NEO datapath width on both sides of the dump memory.
package neo_pkg;

  localparam int NEO_DATA_W = 8;
  localparam int ENERGY_W   = 2 * NEO_DATA_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CAPT = 2'd2
  } state_t;

endpackage

// File: rtl/neo_spike_reader_if.sv
// Read-side bus between the energy dump memory, the spike reader and the event logger.
// The master modport is the reader; the slave modport is the memory/logger environment.
interface neo_spike_reader_if #(
  parameter int EW = 16,
  parameter int TW = 16,
  parameter int CW = 8
);

  logic                 Enable;
  logic                 Empty;
  logic                 read_en;
  logic signed [EW-1:0] Data_in;
  logic signed [EW-1:0] Threshold;
  logic                 Spike;
  logic [TW-1:0]        Timestamp;
  logic signed [EW-1:0] Peak;
  logic [CW-1:0]        Spike_count;
  logic                 Busy;

  modport master (
    input  Enable, Empty, Data_in, Threshold,
    output read_en, Spike, Timestamp, Peak, Spike_count, Busy
  );

  modport slave (
    output Enable, Empty, Data_in, Threshold,
    input  read_en, Spike, Timestamp, Peak, Spike_count, Busy
  );

endinterface

// File: rtl/neo_ema_thresh.sv
// Adaptive threshold: EMA of |sample| kept with A fractional bits, scaled by 2^G,
// saturated to the signed max and floored at the static threshold.
module neo_ema_thresh
  import neo_pkg::*;
#(
  parameter int EW = ENERGY_W,
  parameter int A  = 4,
  parameter int G  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_capt,
  input  logic signed [EW-1:0] i_data,
  input  logic signed [EW-1:0] i_threshold,
  output logic signed [EW-1:0] o_eff_thresh
);

  localparam int MW = EW + A;
  localparam logic [EW-1:0] SMAX = {1'b0, {(EW-1){1'b1}}};
  localparam logic [EW-1:0] SMIN = {1'b1, {(EW-1){1'b0}}};

  logic [MW-1:0]        r_ema;
  logic [EW-1:0]        w_abs;
  logic signed [MW:0]   w_diff;
  logic signed [MW:0]   w_step;
  logic                 w_unused_msb;
  logic [EW+G-1:0]      w_cand;
  logic signed [EW-1:0] w_cand_sat;

  // The most negative sample has no positive twin, so its magnitude clips to SMAX
  assign w_abs = !i_data[EW-1] ? i_data : ((i_data == SMIN) ? SMAX : -i_data);

  assign w_diff       = $signed((MW+1)'(w_abs) << A) - $signed((MW+1)'(r_ema));
  assign w_step       = w_diff >>> A;
  assign w_unused_msb = w_step[MW];

  assign w_cand       = (EW+G)'(r_ema[MW-1:A]) << G;
  assign w_cand_sat   = (w_cand > (EW+G)'(SMAX)) ? SMAX : w_cand[EW-1:0];
  assign o_eff_thresh = (i_threshold > w_cand_sat) ? i_threshold : w_cand_sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ema <= '0;
    end else if (i_capt) begin
      r_ema <= r_ema + w_step[MW-1:0];
    end
  end

endmodule

// File: rtl/neo_spike_reader.sv
// Drains the NEO energy dump memory, one sample per two clocks, and flags threshold crossings
// with a refractory window. Optional macro NEO_ADAPT_THRESH_EN adds an EMA-based threshold.
module neo_spike_reader
  import neo_pkg::*;
#(
  parameter int Energy_width = ENERGY_W,
  parameter int TS_width     = 16,
  parameter int Count_width  = 8,
  parameter int Refr_len     = 4,
  parameter int Alpha_shift  = 4,
  parameter int Gain_shift   = 2
) (
  input logic                clk,
  input logic                rst,
  neo_spike_reader_if.master bus
);

  localparam int RW = (Refr_len > 0) ? $clog2(Refr_len + 1) : 1;

  state_t                         r_state;
  logic [TS_width-1:0]            r_index;
  logic [TS_width-1:0]            r_timestamp;
  logic [RW-1:0]                  r_refr;
  logic signed [Energy_width-1:0] r_peak;
  logic [Count_width-1:0]         r_count;
  logic                           r_spike;

  logic                           w_capt;
  logic signed [Energy_width-1:0] w_data;
  logic signed [Energy_width-1:0] w_eff_thr;

  assign w_capt = (r_state == CAPT);
  assign w_data = bus.Data_in;

`ifdef NEO_ADAPT_THRESH_EN
  neo_ema_thresh #(
    .EW (Energy_width),
    .A  (Alpha_shift),
    .G  (Gain_shift)
  ) u_ema (
    .clk          (clk),
    .rst          (rst),
    .i_capt       (w_capt),
    .i_data       (w_data),
    .i_threshold  (bus.Threshold),
    .o_eff_thresh (w_eff_thr)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{Alpha_shift, Gain_shift};
  assign w_eff_thr    = bus.Threshold;
`endif

  // Strobe only while the memory actually holds a sample
  assign bus.read_en     = (r_state == REQ) && !bus.Empty;
  assign bus.Busy        = (r_state != IDLE);
  assign bus.Spike       = r_spike;
  assign bus.Timestamp   = r_timestamp;
  assign bus.Peak        = r_peak;
  assign bus.Spike_count = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_index     <= '0;
      r_timestamp <= '0;
      r_refr      <= '0;
      r_peak      <= '0;
      r_count     <= '0;
      r_spike     <= 1'b0;
    end else begin
      r_spike <= 1'b0;

      case (r_state)
        IDLE:    if (bus.Enable && !bus.Empty) r_state <= REQ;
        REQ:     if (!bus.Empty) r_state <= CAPT;
                 else if (!bus.Enable) r_state <= IDLE;
        CAPT:    r_state <= (bus.Enable && !bus.Empty) ? REQ : IDLE;
        default: r_state <= IDLE;
      endcase

      // Data_in is valid during CAPT; refractory samples still extend the event peak
      if (w_capt) begin
        r_index <= r_index + 1'b1;
        if (r_refr != '0) begin
          r_refr <= r_refr - 1'b1;
          if (w_data > r_peak) r_peak <= w_data;
        end else if (w_data > w_eff_thr) begin
          r_spike     <= 1'b1;
          r_timestamp <= r_index;
          r_peak      <= w_data;
          r_refr      <= RW'(Refr_len);
          if (r_count != '1) r_count <= r_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_neo_spike_reader.sv
// Directed bench: two readers (refractory 0 and 2) share one modelled dump memory.
// Table vectors cover detection/refractory; hand sequences cover handshake and reset corners.
module tb_neo_spike_reader;

  typedef struct {
    logic               rst_b;
    logic signed [15:0] thr;
    logic signed [15:0] smp;
    logic               s0;
    logic [15:0]        ts0;
    logic signed [15:0] pk0;
    logic [7:0]         c0;
    logic               s2;
    logic [15:0]        ts2;
    logic signed [15:0] pk2;
    logic [7:0]         c2;
  } vec_t;

  localparam int NV = 12;

  logic               clk         = 1'b0;
  logic               rst         = 1'b0;
  logic               en          = 1'b0;
  logic signed [15:0] thr         = '0;
  logic               empty_force = 1'b0;
  logic signed [15:0] mem [0:1023];
  logic [9:0]         wr_ptr      = '0;
  logic [9:0]         rd_ptr      = '0;
  logic signed [15:0] data_q      = '0;
  logic               empty_w;
  int                 n_vec       = 0;
  int                 n_bad       = 0;
  int                 n_viol      = 0;
  vec_t               vecs [NV];

  always #5 clk = ~clk;

  neo_spike_reader_if #(.EW(16), .TW(16), .CW(8)) if0 ();
  neo_spike_reader_if #(.EW(16), .TW(16), .CW(8)) if2 ();

  assign empty_w       = (rd_ptr == wr_ptr) || empty_force;
  assign if0.Enable    = en;
  assign if0.Empty     = empty_w;
  assign if0.Data_in   = data_q;
  assign if0.Threshold = thr;
  assign if2.Enable    = en;
  assign if2.Empty     = empty_w;
  assign if2.Data_in   = data_q;
  assign if2.Threshold = thr;

  neo_spike_reader #(
    .Energy_width(16), .TS_width(16), .Count_width(8),
    .Refr_len(0), .Alpha_shift(4), .Gain_shift(2)
  ) u_r0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  neo_spike_reader #(
    .Energy_width(16), .TS_width(16), .Count_width(8),
    .Refr_len(2), .Alpha_shift(4), .Gain_shift(2)
  ) u_r2 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  // Synchronous memory: data appears one cycle after the read strobe
  always @(posedge clk) begin
    if (if0.read_en) begin
      data_q <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 10'd1;
    end
  end

  always @(negedge clk) begin
    if (rst && ((if0.read_en && if0.Empty) || (if2.read_en !== if0.read_en))) n_viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic signed [15:0] s);
    mem[wr_ptr] = s;
    wr_ptr = wr_ptr + 10'd1;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    @(negedge clk);
    n = 1;
    while ((if0.Busy || rd_ptr != wr_ptr) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (if0.Busy || rd_ptr != wr_ptr) begin
      n_bad++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic wait_read(input string name);
    int n = 0;
    while (!if0.read_en && n < 8) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (!if0.read_en) begin
      n_bad++;
      $display("FAIL %s: read_en=0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int cnt;
    logic [9:0] rd0;

    vecs[0]  = '{1'b1, 16'sd100,  16'sd50,  1'b0, 16'd0, 16'sd0,   8'd0, 1'b0, 16'd0, 16'sd0,   8'd0};
    vecs[1]  = '{1'b0, 16'sd100,  16'sd101, 1'b1, 16'd1, 16'sd101, 8'd1, 1'b1, 16'd1, 16'sd101, 8'd1};
    vecs[2]  = '{1'b0, 16'sd100,  16'sd100, 1'b0, 16'd1, 16'sd101, 8'd1, 1'b0, 16'd1, 16'sd101, 8'd1};
    vecs[3]  = '{1'b0, 16'sd100, -16'sd200, 1'b0, 16'd1, 16'sd101, 8'd1, 1'b0, 16'd1, 16'sd101, 8'd1};
    vecs[4]  = '{1'b0, 16'sd100,  16'sd300, 1'b1, 16'd4, 16'sd300, 8'd2, 1'b1, 16'd4, 16'sd300, 8'd2};
    vecs[5]  = '{1'b1, 16'sd10,   16'sd20,  1'b1, 16'd0, 16'sd20,  8'd1, 1'b1, 16'd0, 16'sd20,  8'd1};
    vecs[6]  = '{1'b0, 16'sd10,   16'sd50,  1'b1, 16'd1, 16'sd50,  8'd2, 1'b0, 16'd0, 16'sd50,  8'd1};
    vecs[7]  = '{1'b0, 16'sd10,   16'sd5,   1'b0, 16'd1, 16'sd50,  8'd2, 1'b0, 16'd0, 16'sd50,  8'd1};
    vecs[8]  = '{1'b0, 16'sd10,   16'sd30,  1'b1, 16'd3, 16'sd30,  8'd3, 1'b1, 16'd3, 16'sd30,  8'd2};
    vecs[9]  = '{1'b1, -16'sd10, -16'sd5,   1'b1, 16'd0, -16'sd5,  8'd1, 1'b1, 16'd0, -16'sd5,  8'd1};
    vecs[10] = '{1'b0, -16'sd10, -16'sd10,  1'b0, 16'd0, -16'sd5,  8'd1, 1'b0, 16'd0, -16'sd5,  8'd1};
    vecs[11] = '{1'b0, -16'sd10, -16'sd4,   1'b1, 16'd2, -16'sd4,  8'd2, 1'b0, 16'd0, -16'sd4,  8'd1};

    repeat (2) @(negedge clk);
    chk("rst.spike0",   int'(if0.Spike),       0);
    chk("rst.ts0",      int'(if0.Timestamp),   0);
    chk("rst.peak0",    int'(if0.Peak),        0);
    chk("rst.count0",   int'(if0.Spike_count), 0);
    chk("rst.busy0",    int'(if0.Busy),        0);
    chk("rst.read_en0", int'(if0.read_en),     0);
    chk("rst.count2",   int'(if2.Spike_count), 0);
    chk("rst.busy2",    int'(if2.Busy),        0);
    rst = 1'b1;
    en  = 1'b1;

`ifdef NEO_ADAPT_THRESH_EN
    do_reset;
    thr = 16'sd0;
    for (int i = 0; i < 64; i++) push(16'sd40);
    drain("ema.warm1", 400);
    push(16'sd150);
    drain("ema.s150", 20);
    chk("ema.spike_150", int'(if0.Spike), 0);
    do_reset;
    for (int i = 0; i < 64; i++) push(16'sd40);
    drain("ema.warm2", 400);
    push(16'sd170);
    drain("ema.s170", 20);
    chk("ema.spike_170", int'(if0.Spike), 1);
`else
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].rst_b) do_reset;
      thr = vecs[i].thr;
      push(vecs[i].smp);
      drain($sformatf("v%0d.drain", i), 20);
      chk($sformatf("v%0d.spike0", i), int'(if0.Spike),       int'(vecs[i].s0));
      chk($sformatf("v%0d.ts0", i),    int'(if0.Timestamp),   int'(vecs[i].ts0));
      chk($sformatf("v%0d.peak0", i),  int'(if0.Peak),        int'(vecs[i].pk0));
      chk($sformatf("v%0d.count0", i), int'(if0.Spike_count), int'(vecs[i].c0));
      chk($sformatf("v%0d.spike2", i), int'(if2.Spike),       int'(vecs[i].s2));
      chk($sformatf("v%0d.ts2", i),    int'(if2.Timestamp),   int'(vecs[i].ts2));
      chk($sformatf("v%0d.peak2", i),  int'(if2.Peak),        int'(vecs[i].pk2));
      chk($sformatf("v%0d.count2", i), int'(if2.Spike_count), int'(vecs[i].c2));
      if (vecs[i].s0) begin
        @(negedge clk);
        chk($sformatf("v%0d.spike0_fall", i), int'(if0.Spike), 0);
      end
    end

    // Counter saturation over 256 back-to-back detections
    do_reset;
    thr = 16'sd0;
    for (int i = 0; i < 256; i++) push(16'sd200);
    drain("sat.drain", 1200);
    chk("sat.count0", int'(if0.Spike_count), 255);
    chk("sat.ts0",    int'(if0.Timestamp),   255);
    chk("sat.peak0",  int'(if0.Peak),        200);
    chk("sat.count2", int'(if2.Spike_count), 86);
    chk("sat.ts2",    int'(if2.Timestamp),   255);

    // Hold REQ with Empty forced high, then release
    do_reset;
    thr = 16'sd100;
    push(16'sd5);
    @(posedge clk);
    #1 empty_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("hold%0d.read_en", i), int'(if0.read_en), 0);
    end
    chk("hold.busy", int'(if0.Busy), 1);
    rd0 = rd_ptr;
    empty_force = 1'b0;
    #1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (if0.read_en) cnt++;
      @(negedge clk);
    end
    chk("toggle.pulses", cnt, 1);
    chk("toggle.reads",  int'(10'(rd_ptr - rd0)), 1);
    chk("toggle.busy",   int'(if0.Busy), 0);

    // Enable falls while the read is in flight
    do_reset;
    push(16'sd300);
    push(16'sd7);
    wait_read("drop.wait");
    @(posedge clk);
    #1 en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("drop.spike0", int'(if0.Spike), 1);
    chk("drop.peak0",  int'(if0.Peak),  300);
    chk("drop.busy",   int'(if0.Busy),  0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if0.read_en) cnt++;
    end
    chk("drop.extra_reads", cnt, 0);
    chk("drop.busy_after",  int'(if0.Busy), 0);
    chk("drop.left",        int'(10'(wr_ptr - rd_ptr)), 1);
    en = 1'b1;
    drain("drop.drain", 20);
    chk("drop.count0", int'(if0.Spike_count), 1);

    // Reset asserted during CAPT
    push(16'sd300);
    wait_read("rcapt.wait");
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rcapt.busy0",  int'(if0.Busy),        0);
    chk("rcapt.peak0",  int'(if0.Peak),        0);
    chk("rcapt.count0", int'(if0.Spike_count), 0);
    chk("rcapt.spike0", int'(if0.Spike),       0);
    en = 1'b0;
    push(16'sd9);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (if0.Busy || if0.read_en) cnt++;
    end
    chk("rcapt.stay_idle", cnt, 0);
    en = 1'b1;
    drain("rcapt.drain", 20);
    chk("rcapt.ts0", int'(if0.Timestamp), 0);
`endif

    chk("read_en_rules", n_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/neo_spike_reader.md
Name: neo_spike_reader

Overview:
- Read-side consumer of the NEO energy dump memory. The NEO block writes with write_en/Full; this block drains that memory with read_en/Empty.
- Fetches each 16-bit signed energy sample and compares it against a threshold. Emits a one-cycle spike pulse with timestamp and peak.
- Enforces a sample-counted refractory window after each detection.
- Sits between the dump memory and the downstream event logger.

Parameters:
- Energy_width, 16, width of stored NEO samples (equals 2 × NEO Data_width).
- TS_width, 16, width of the sample index / timestamp counter.
- Count_width, 8, width of the spike counter.
- Refr_len, 4, samples consumed without detection after a spike (0 = no refractory).
- Alpha_shift, 4, EMA smoothing shift (used only with the optional feature).
- Gain_shift, 2, multiplier 2^Gain_shift applied to the EMA (used only with the optional feature).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset; rst=0 resets immediately.
- Enable  input  1  level; allows new reads while high.
- Empty  input  1  memory has no unread sample.
- read_en  output  1  one-cycle read strobe to memory.
- Data_in  input  Energy_width  signed sample; valid exactly one cycle after read_en.
- Threshold  input  Energy_width  signed static detection threshold.
- Spike  output  1  one-cycle pulse per detection.
- Timestamp  output  TS_width  sample index of last detection.
- Peak  output  Energy_width  max sample of the current/last event, including refractory samples.
- Spike_count  output  Count_width  detections since reset, saturating.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - read_en=0, Spike=0, Timestamp=0, Peak=0, Spike_count=0, Busy=0.
  - Sample index=0, refractory counter=0.
- FSM states:
  - IDLE: Enable && ~Empty → REQ; otherwise stay.
  - REQ: read_en = ~Empty (combinational, Moore-gated).
    - Empty=0 → CAPT.
    - Empty=1 && Enable → stay REQ.
    - Empty=1 && ~Enable → IDLE.
  - CAPT: Data_in is sampled this cycle.
    - Enable && ~Empty → REQ; else → IDLE.
    - Throughput is one sample per 2 clocks.
- Per captured sample (CAPT edge):
  - Sample index increments and wraps at 2^TS_width.
  - If refractory counter > 0: decrement; Peak <= max(Peak, Data_in); no spike.
  - Else if Data_in > Threshold (signed, strict):
    - Spike <= 1 for the next cycle only.
    - Timestamp <= current index, pre-increment.
    - Peak <= Data_in.
    - Spike_count <= Spike_count+1, holding at all-ones.
    - Refractory counter <= Refr_len.
  - Else: no change.
- Spike is registered and deasserts on the following edge unless a new detection occurs. Back-to-back detections are possible only when Refr_len=0.
- Enable falling mid-transaction:
  - A read already issued (state CAPT) still completes and is evaluated.
  - No new read_en is issued.
- Empty is evaluated only in IDLE/REQ. read_en is never asserted while Empty=1.
- Spike_count saturates; Timestamp wraps silently.
- Reset mid-read: the in-flight sample is discarded; memory pointer consistency is the memory's responsibility.

Optional Feature:
- Macro: NEO_ADAPT_THRESH_EN.
- Defined:
  - Keep ema (Energy_width+Alpha_shift bits, reset 0).
  - Update on every captured sample: ema += (|Data_in| − ema) >> Alpha_shift, using a sign-correct arithmetic shift.
  - Effective threshold = max(Threshold, (ema>>Alpha_shift) << Gain_shift), saturated to the signed max.
  - The EMA also updates during refractory.
- Undefined: effective threshold = Threshold. No EMA logic is generated; port list is unchanged.

Decomposition:
- Shared package neo_pkg:
  - State encoding constants IDLE/REQ/CAPT.
  - ENERGY_W=16 and NEO Data_width=8, so writer and reader widths stay consistent.
- One sub-module, neo_ema_thresh: EMA and effective-threshold computation, instantiated only under NEO_ADAPT_THRESH_EN.

Test Plan:
- Reset with rst=0 mid-CAPT → all outputs 0 the same cycle; stays IDLE after rst=1 while Enable=0.
- Threshold=100, Refr_len=0, samples 50,101,100,−200,300 → Spike after the 2nd and 5th samples; Timestamp=1 then 4; Spike_count=2; Peak=300.
- Threshold=10, Refr_len=2, samples 20,50,5,30 → single Spike at index 0; Peak=50; the 4th sample (30) spikes at index 3.
- Empty toggling: Empty=1 for 5 cycles while in REQ with Enable=1 → read_en stays 0; read_en pulses exactly once when Empty drops; no duplicate reads.
- Enable dropped the cycle after read_en → that sample is still evaluated; no further read_en; FSM returns to IDLE; Busy=0.
- 256 samples of 200 with Threshold=0, Refr_len=0, Count_width=8 → Spike_count holds at 255.
- With NEO_ADAPT_THRESH_EN, Threshold=0:
  - 64 samples of 40 → ema≈40, effective threshold≈160.
  - Sample 150 → no Spike; sample 170 → Spike.
